// File: rtl/regfile_wb_arbiter_if.sv
//------------------------------------------------------------------------------
// Module  : regfile_wb_arbiter_if
// Brief   : Writeback requester handshakes plus the register-file write port.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_wb_arbiter_if;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        rf_en;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_en, rf_addr, rf_data
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_en, rf_addr, rf_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : regfile_wb_arbiter
// Brief   : Zero-fills registers 1..31 after reset, then round-robin shares the
//           register-file write port between the ALU (A) and load unit (B).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int STALL_W        = 16
) (
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    regfile_wb_arbiter_if.slave     bus,
    output logic                    init_done_o,
    output logic [STALL_W-1:0]      stall_cnt_o
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e c_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [STALL_W-1:0] c_STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [4:0]           clr_ptr_q, clr_ptr_d;
    logic                 prio_q, prio_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 w_grant_a;
    logic                 w_grant_b;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= c_RESET_STATE;
            clr_ptr_q <= 5'd1;
            prio_q    <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            prio_q    <= prio_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        prio_d      = prio_q;
        stall_d     = stall_q;
        w_grant_a   = 1'b0;
        w_grant_b   = 1'b0;
        bus.rf_en   = 1'b0;
        bus.rf_addr = 5'd0;
        bus.rf_data = 32'd0;
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        init_done_o = 1'b0;

        // Everything stays quiet while reset is held so no request slips through.
        if (!reset_i) begin
            case (state_q)
                ST_CLEAR: begin
                    bus.rf_en   = 1'b1;
                    bus.rf_addr = clr_ptr_q;
                    clr_ptr_d   = clr_ptr_q + 5'd1;
                    if (clr_ptr_q == 5'd31) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done_o = 1'b1;
                    w_grant_a   = bus.a_valid && (!bus.b_valid || !prio_q);
                    w_grant_b   = bus.b_valid && !w_grant_a;
                    if (w_grant_a) begin
                        bus.a_ready = 1'b1;
                        bus.rf_addr = bus.a_addr;
                        bus.rf_data = bus.a_data;
                        bus.rf_en   = (bus.a_addr != 5'd0);
                    end else if (w_grant_b) begin
                        bus.b_ready = 1'b1;
                        bus.rf_addr = bus.b_addr;
                        bus.rf_data = bus.b_data;
                        bus.rf_en   = (bus.b_addr != 5'd0);
                    end
                    // The loser of a contested cycle gets priority next time.
                    if (bus.a_valid && bus.b_valid) begin
                        prio_d = w_grant_a;
                    end
                    if (((bus.a_valid && !w_grant_a) || (bus.b_valid && !w_grant_b))
                        && (stall_q != {STALL_W{1'b1}})) begin
                        stall_d = stall_q + c_STALL_ONE;
                    end
                end
                default: state_d = c_RESET_STATE;
            endcase
        end
    end

    assign stall_cnt_o = reset_i ? '0 : stall_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_regfile_wb_arbiter
// Brief   : Self-checking bench for regfile_wb_arbiter against a behavioural model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;

    // {rf_en, rf_addr, rf_data, a_ready, b_ready, init_done, stall_cnt}
    typedef logic [56:0] obs_t;
    localparam int c_STALL_MAX = 65535;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if if0 ();
    regfile_wb_arbiter_if if1 ();
    logic        done0, done1;
    logic [15:0] st0;
    logic [3:0]  st1;

    regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b1), .STALL_W(16)) u_dut0 (
        .clk_i(clk), .reset_i(rst), .bus(if0), .init_done_o(done0), .stall_cnt_o(st0)
    );
    regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b0), .STALL_W(4)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .bus(if1), .init_done_o(done1), .stall_cnt_o(st1)
    );

    int   total = 0;
    int   bad   = 0;
    bit   m_run;
    int   m_ptr, m_prio, m_stall;
    obs_t e_obs, e_mask, o_obs;
    bit   e_ar, e_br;

    // Reference model: expected outputs for this cycle, taken at the falling edge.
    task automatic sample();
        int          win;
        logic [4:0]  ad;
        logic [31:0] da;
        @(negedge clk);
        o_obs  = {if0.rf_en, if0.rf_addr, if0.rf_data, if0.a_ready, if0.b_ready, done0, st0};
        e_mask = '1;
        e_ar   = 1'b0;
        e_br   = 1'b0;
        if (rst) begin
            e_obs = '0;
        end else if (!m_run) begin
            e_obs = {1'b1, 5'(m_ptr), 32'd0, 1'b0, 1'b0, 1'b0, 16'(m_stall)};
        end else begin
            if (if0.a_valid && if0.b_valid) win = (m_prio == 0) ? 1 : 2;
            else if (if0.a_valid)           win = 1;
            else if (if0.b_valid)           win = 2;
            else                            win = 0;
            e_ar  = (win == 1);
            e_br  = (win == 2);
            ad    = (win == 1) ? if0.a_addr : if0.b_addr;
            da    = (win == 1) ? if0.a_data : if0.b_data;
            e_obs = {(win != 0) && (ad != 5'd0), ad, da, e_ar, e_br, 1'b1, 16'(m_stall)};
            if (win == 0) e_mask[55:19] = '0;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0; m_ptr = 1; m_prio = 0; m_stall = 0;
        end else if (!m_run) begin
            if (m_ptr == 31) m_run = 1'b1;
            m_ptr++;
        end else begin
            if (if0.a_valid && if0.b_valid) m_prio = e_ar ? 1 : 0;
            if ((if0.a_valid && !e_ar) || (if0.b_valid && !e_br))
                m_stall = (m_stall < c_STALL_MAX) ? m_stall + 1 : m_stall;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.a_valid = 1'b1; if0.a_addr = 5'd7; if0.a_data = 32'h1111_2222;
        if0.b_valid = 1'b1; if0.b_addr = 5'd8; if0.b_data = 32'h3333_4444;
        if1.a_valid = 1'b1; if1.a_addr = 5'd7; if1.a_data = 32'h5;
        if1.b_valid = 1'b1; if1.b_addr = 5'd8; if1.b_data = 32'h6;
        for (int i = 0; i < 2; i++) begin
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL reset0 i=%0d got=%h want=%h", i, o_obs & e_mask, e_obs & e_mask);
            end
            total++;
            if ({if1.a_ready, if1.b_ready, if1.rf_en, done1, st1} !== 8'd0) begin
                bad++; $display("FAIL reset1 i=%0d got=%b want=0", i, {if1.a_ready, if1.b_ready, if1.rf_en, done1, st1});
            end
            advance();
        end
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;
        if1.a_valid = 1'b0; if1.b_valid = 1'b0;
    endtask

    task automatic test_clear();
        int first = 0;
        rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL clear c=%0d got=%h want=%h", c, o_obs & e_mask, e_obs & e_mask);
            end
            if (c == 1) begin
                total++;
                if (done1 !== 1'b1) begin
                    bad++; $display("FAIL noclear_done got=%b want=1", done1);
                end
            end
            if (done0 === 1'b1 && first == 0) first = c;
            advance();
        end
        total++;
        if (first != 32) begin
            bad++; $display("FAIL init_done_cycle got=%0d want=32", first);
        end
    endtask

    task automatic test_contention();
        int base = m_stall;
        if0.a_valid = 1'b1; if0.a_addr = 5'd5; if0.a_data = 32'hAAAA_0000;
        if0.b_valid = 1'b1; if0.b_addr = 5'd6; if0.b_data = 32'hBBBB_0000;
        for (int i = 0; i < 8; i++) begin
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL contend i=%0d got=%h want=%h", i, o_obs & e_mask, e_obs & e_mask);
            end
            total++;
            if ({if0.a_ready, if0.b_ready} !== {1'(i % 2 == 0), 1'(i % 2 == 1)} || st0 !== 16'(base + i)) begin
                bad++; $display("FAIL alternate i=%0d got=%b/%0d want=%b/%0d", i,
                                {if0.a_ready, if0.b_ready}, st0, {1'(i % 2 == 0), 1'(i % 2 == 1)}, base + i);
            end
            advance();
        end
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    endtask

    task automatic test_addr0();
        int base = m_stall;
        if0.a_valid = 1'b1; if0.a_addr = 5'd0; if0.a_data = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL addr0 i=%0d got=%h want=%h", i, o_obs & e_mask, e_obs & e_mask);
            end
            total++;
            if (if0.a_ready !== 1'b1 || if0.rf_en !== 1'b0 || st0 !== 16'(base)) begin
                bad++; $display("FAIL addr0_x i=%0d got=%b%b/%0d want=10/%0d", i, if0.a_ready, if0.rf_en, st0, base);
            end
            advance();
        end
        if0.a_valid = 1'b0;
    endtask

    task automatic test_clear_request();
        rst = 1'b1; sample(); advance(); rst = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                if0.b_valid = 1'b1; if0.b_addr = 5'd9; if0.b_data = 32'h1234_5678;
            end
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL clrreq c=%0d got=%h want=%h", c, o_obs & e_mask, e_obs & e_mask);
            end
            total++;
            if (if0.b_ready !== 1'(c == 32) || st0 !== 16'd0 || (c == 32 && if0.rf_addr !== 5'd9)) begin
                bad++; $display("FAIL clrreq_x c=%0d got=%b/%0d/%0d want=%b/0", c, if0.b_ready, st0, if0.rf_addr, 1'(c == 32));
            end
            advance();
            if (e_br) if0.b_valid = 1'b0;
        end
        if0.b_valid = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        rst = 1'b1; sample(); advance(); rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL midclr c=%0d got=%h want=%h", c, o_obs & e_mask, e_obs & e_mask);
            end
            advance();
        end
        rst = 1'b1;
        sample();
        total++;
        if (if0.rf_en !== 1'b0 || done0 !== 1'b0) begin
            bad++; $display("FAIL midclr_rst got=%b%b want=00", if0.rf_en, done0);
        end
        advance();
        rst = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL restart c=%0d got=%h want=%h", c, o_obs & e_mask, e_obs & e_mask);
            end
            total++;
            if (done0 !== 1'(c >= 32) || (c <= 31 && if0.rf_addr !== 5'(c))) begin
                bad++; $display("FAIL restart_x c=%0d got=%b/%0d want=%b/%0d", c, done0, if0.rf_addr, 1'(c >= 32), c);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!if0.a_valid && $urandom_range(0, 1) == 1) begin
                if0.a_valid = 1'b1; if0.a_addr = 5'($urandom_range(0, 31)); if0.a_data = $urandom;
            end
            if (!if0.b_valid && $urandom_range(0, 1) == 1) begin
                if0.b_valid = 1'b1; if0.b_addr = 5'($urandom_range(0, 31)); if0.b_data = $urandom;
            end
            sample();
            total++;
            if ((o_obs & e_mask) !== (e_obs & e_mask)) begin
                bad++; $display("FAIL random i=%0d got=%h want=%h", i, o_obs & e_mask, e_obs & e_mask);
            end
            advance();
            if (e_ar) if0.a_valid = 1'b0;
            if (e_br) if0.b_valid = 1'b0;
        end
        rst = 1'b0;
        if0.a_valid = 1'b0; if0.b_valid = 1'b0;
    endtask

    task automatic test_saturate();
        rst = 1'b1; sample(); advance(); rst = 1'b0;
        if1.a_valid = 1'b1; if1.a_addr = 5'd3; if1.a_data = 32'hC0DE_0003;
        if1.b_valid = 1'b1; if1.b_addr = 5'd4; if1.b_data = 32'hC0DE_0004;
        for (int i = 0; i < 20; i++) begin
            sample();
            total++;
            if (done1 !== 1'b1 || st1 !== 4'((i < 15) ? i : 15) ||
                if1.a_ready !== 1'(i % 2 == 0) || if1.b_ready !== 1'(i % 2 == 1)) begin
                bad++; $display("FAIL saturate i=%0d got=%b/%0d/%b%b want=1/%0d/%b%b", i, done1, st1,
                                if1.a_ready, if1.b_ready, (i < 15) ? i : 15, 1'(i % 2 == 0), 1'(i % 2 == 1));
            end
            advance();
        end
        sample();
        total++;
        if (st1 !== 4'd15) begin
            bad++; $display("FAIL saturate_end got=%0d want=15", st1);
        end
        advance();
        if1.a_valid = 1'b0; if1.b_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_run = 1'b0; m_ptr = 1; m_prio = 0; m_stall = 0;
        if0.a_valid = 1'b0; if0.a_addr = 5'd0; if0.a_data = 32'd0;
        if0.b_valid = 1'b0; if0.b_addr = 5'd0; if0.b_data = 32'd0;
        if1.a_valid = 1'b0; if1.a_addr = 5'd0; if1.a_data = 32'd0;
        if1.b_valid = 1'b0; if1.b_addr = 5'd0; if1.b_data = 32'd0;
        #1;
        test_reset();
        test_clear();
        test_contention();
        test_addr0();
        test_clear_request();
        test_reset_mid_clear();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 register file. After reset it sequences a zero-fill of registers 1..31, one per cycle, because the register file's own reset clears only register 0. It then shares the single write port between two writeback requesters, the ALU (A) and the load unit (B), using valid/ready handshakes and round-robin arbitration. It sits between the writeback stage and the register file's D_En/D_Addr/D inputs.

## Interface
- CLEAR_ON_RESET, 1: 1 runs the zero-fill sequence after reset; 0 enters RUN directly.
- STALL_W, 16: width of the saturating stall counter.
- clk  in  1  rising-edge clock
- reset  in  1  one clock; reset is synchronous and active-high
- a_valid  in  1  requester A has a write pending
- a_addr  in  5  requester A destination register
- a_data  in  32  requester A write data
- a_ready  out  1  requester A write accepted this cycle
- b_valid  in  1  requester B has a write pending
- b_addr  in  5  requester B destination register
- b_data  in  32  requester B write data
- b_ready  out  1  requester B write accepted this cycle
- rf_en  out  1  to register file D_En
- rf_addr  out  5  to register file D_Addr
- rf_data  out  32  to register file D
- init_done  out  1  high once the zero-fill is complete (RUN state)
- stall_cnt  out  STALL_W  count of cycles a valid requester was refused, saturating

## Operation
- States:
  - CLEAR: zero-fill in progress.
  - RUN: arbitration.
- Registered state:
  - state
  - clr_ptr (5 bits)
  - prio (0 = A preferred, 1 = B preferred)
  - stall_cnt
- Reset (sampled high at a clk edge):
  - state <= CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_ptr <= 1.
  - prio <= 0.
  - stall_cnt <= 0.
- While reset is high, rf_en, a_ready and b_ready are forced 0 combinationally.
- CLEAR:
  - Outputs: rf_en=1, rf_addr=clr_ptr, rf_data=0, a_ready=b_ready=0, init_done=0.
  - clr_ptr increments each cycle.
  - When clr_ptr==31, state <= RUN on that edge.
  - Requests are ignored; requesters hold valid/addr/data until ready.
- RUN, init_done=1. Grant is computed combinationally from valids and prio:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant A if prio==0, else B.
  - Neither valid: no grant, rf_en=0.
- Granted requester:
  - Its ready=1; the other ready=0.
  - rf_addr and rf_data come from the granted requester.
  - rf_en=1 unless the granted addr==0.
- Address-0 write: accepted (ready=1) and discarded with rf_en=0, so register 0 stays 0.
- prio update:
  - On a contested grant, prio <= the loser.
  - Uncontested grants and idle cycles leave prio unchanged.
- Stall counting: stall_cnt increments by 1 each RUN cycle in which a valid requester has ready=0, saturating at all-ones. Refused CLEAR cycles do not count.
- Outputs are combinational from state and inputs, so a handshake and its register-file write occur on the same clk edge.

## Timing
- Accept-to-write latency is 0 cycles; the write lands on the edge where valid&&ready.
- Zero-fill timing (CLEAR_ON_RESET=1):
  - Takes exactly 31 cycles after reset deasserts: addresses 1,2,...,31 on consecutive cycles.
  - init_done rises in cycle 32 and is the first RUN cycle.
- With CLEAR_ON_RESET=0, init_done=1 in the first cycle after reset deasserts.
- Throughput: one write per cycle. Under continuous contention, A and B alternate every cycle.
- Reset during CLEAR or RUN:
  - Aborts immediately; any in-flight request is not accepted in the reset cycle.
  - CLEAR restarts from address 1.
- Reset values: a_ready=0, b_ready=0, rf_en=0, init_done=0, stall_cnt=0.
  - rf_addr=0 and rf_data=0 while reset is high.
- Requesters must hold valid, addr and data stable until ready; the arbiter makes no buffering guarantee otherwise.

## Test plan
- Reset, then idle 40 cycles:
  - rf_en=1 with rf_addr 1..31 and rf_data=0 in cycles 1..31.
  - init_done=1 from cycle 32; rf_en=0 afterwards.
- Both requesters valid continuously after init, A addr 5 data 0xAAAA0000, B addr 6 data 0xBBBB0000:
  - Grants alternate A,B,A,B starting with A.
  - stall_cnt increments every cycle.
- A valid only, addr 0 data 0xFFFFFFFF: a_ready=1, rf_en=0, stall_cnt unchanged.
- B requests during CLEAR at cycle 10:
  - b_ready=0 until the first RUN cycle, then b_ready=1 with rf_addr=B addr.
  - stall_cnt stays 0.
- Reset asserted at CLEAR cycle 15, released 1 cycle later:
  - Clear restarts at rf_addr=1.
  - init_done low until 31 more cycles elapse.
- STALL_W=4, both valid for 20 RUN cycles: stall_cnt saturates at 15.
